alu_mul_seq: RTL and testbench



---
 rtl/alu_mul_seq_pkg.sv | 20 ++
 rtl/alu_mul_seq_alu.sv | 24 ++
 rtl/alu_mul_seq.sv | 148 ++++++++++++++
 tb/tb_alu_mul_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mul_seq_pkg.sv
// Shared ALU control words and multiplier sequencer state encodings.
package alu_mul_seq_pkg;

   // Control word bit order: {zx, nx, zy, ny, f, no}
   localparam logic [5:0] OP_ZERO = 6'b101010;
   localparam logic [5:0] OP_X    = 6'b001100;
   localparam logic [5:0] OP_Y    = 6'b110000;
   localparam logic [5:0] OP_ADD  = 6'b000010;
   localparam logic [5:0] OP_XMY  = 6'b010011;
   localparam logic [5:0] OP_AND  = 6'b000000;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StCheck = 3'd1,
      StAdd   = 3'd2,
      StDbl   = 3'd3,
      StDone  = 3'd4
   } state_t;

endpackage

// File: rtl/alu_mul_seq_alu.sv
// Hack-style combinational ALU: zx/nx/zy/ny/f/no control with zr/ng flags.
module alu_mul_seq_alu #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [5:0]       ctrl,
   output logic [WIDTH-1:0] out,
   output logic             zr,
   output logic             ng
);

   logic [WIDTH-1:0] x_z, x_n, y_z, y_n, f_out;

   assign x_z   = ctrl[5] ? '0 : x;
   assign x_n   = ctrl[4] ? ~x_z : x_z;
   assign y_z   = ctrl[3] ? '0 : y;
   assign y_n   = ctrl[2] ? ~y_z : y_z;
   assign f_out = ctrl[1] ? (x_n + y_n) : (x_n & y_n);
   assign out   = ctrl[0] ? ~f_out : f_out;
   assign zr    = (out == '0);
   assign ng    = out[WIDTH-1];

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential shift-and-add multiplier driving a single Hack ALU from an FSM.
// Optional sticky overflow flag and port enabled by defining ALU_MUL_OVF_EN.
module alu_mul_seq
   import alu_mul_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
`ifdef ALU_MUL_OVF_EN
   ,
   output logic             ovf
`endif
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0] product_q, product_d;

   logic [WIDTH-1:0] alu_x, alu_y, alu_out;
   logic [5:0]       alu_ctrl;
   logic             alu_zr;
   logic             unused_alu_ng;

   alu_mul_seq_alu #(
      .WIDTH(WIDTH)
   ) u_alu (
      .x    (alu_x),
      .y    (alu_y),
      .ctrl (alu_ctrl),
      .out  (alu_out),
      .zr   (alu_zr),
      .ng   (unused_alu_ng)
   );

   // ALU operand/control mux selected by state
   always_comb begin
      alu_x    = '0;
      alu_y    = '0;
      alu_ctrl = OP_ZERO;
      unique case (state_q)
         StCheck: begin
            alu_x    = m_q;
            alu_ctrl = OP_X;
         end
         StAdd: begin
            alu_x    = p_q;
            alu_y    = a_q;
            alu_ctrl = OP_ADD;
         end
         StDbl: begin
            alu_x    = a_q;
            alu_y    = a_q;
            alu_ctrl = OP_ADD;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      m_d       = m_q;
      p_d       = p_q;
      product_d = product_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = a;
               m_d     = b;
               p_d     = '0;
               state_d = StCheck;
            end
         end
         StCheck: begin
            if (alu_zr)      state_d = StDone;
            else if (m_q[0]) state_d = StAdd;
            else             state_d = StDbl;
         end
         StAdd: begin
            p_d     = alu_out;
            state_d = StDbl;
         end
         StDbl: begin
            a_d     = alu_out;
            m_d     = m_q >> 1;
            state_d = StCheck;
         end
         StDone: begin
            product_d = p_q;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         a_q       <= '0;
         m_q       <= '0;
         p_q       <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         m_q       <= m_d;
         p_q       <= p_d;
         product_q <= product_d;
      end
   end

   assign busy    = (state_q != StIdle);
   assign done    = (state_q == StDone);
   assign product = product_q;

`ifdef ALU_MUL_OVF_EN
   logic ovf_q, ovf_d;

   // Sticky: carry out of an add, or doubling drops a bit while multiplier bits remain
   always_comb begin
      ovf_d = ovf_q;
      if (state_q == StIdle && start) begin
         ovf_d = 1'b0;
      end else if (state_q == StAdd && alu_out < p_q) begin
         ovf_d = 1'b1;
      end else if (state_q == StDbl && a_q[WIDTH-1] && (|m_q[WIDTH-1:1])) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) ovf_q <= 1'b0;
      else       ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq using a scoreboard of expected results.
module tb_alu_mul_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] a, b;
   logic        busy, done;
   logic [15:0] product;
`ifdef ALU_MUL_OVF_EN
   logic        ovf;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] product;
      logic        ovf;
      int          lat;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   alu_mul_seq #(
      .WIDTH(16)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
`ifdef ALU_MUL_OVF_EN
      ,
      .ovf     (ovf)
`endif
   );

   function automatic int calc_lat(input logic [15:0] v);
      int k = 0;
      for (int i = 0; i < 16; i++) if (v[i]) k = i + 1;
      return 2 + 2 * k + $countones(v);
   endfunction

   function automatic exp_t model(input logic [15:0] ia, input logic [15:0] ib);
      exp_t        e;
      logic [31:0] full;
      full      = {16'h0, ia} * {16'h0, ib};
      e.product = full[15:0];
      e.ovf     = (full[31:16] != 16'h0);
      e.lat     = calc_lat(ib);
      return e;
   endfunction

   // Waits (bounded) for done starting in cycle 1; returns the cycle number reached.
   task automatic wait_done(input string name, output int n);
      int bad_busy = 0;
      n = 1;
      while (done !== 1'b1 && n <= 60) begin
         if (busy !== 1'b1) bad_busy++;
         @(negedge clk);
         n++;
      end
      if (busy !== 1'b1) bad_busy++;
      checks++;
      if (bad_busy != 0) begin
         errors++;
         $display("FAIL %s busy_low_while_running: got %0d low cycles, want 0", name, bad_busy);
      end
   endtask

   // Pops the scoreboard and checks latency, then the result in cycle L+1.
   task automatic check_result(input string name, input int n);
      exp_t e;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard_empty", name);
         return;
      end
      e = sb.pop_front();
      checks++;
      if (n !== e.lat) begin
         errors++;
         $display("FAIL %s latency: got %0d, want %0d", name, n, e.lat);
      end
      @(negedge clk);
      checks++;
      if (product !== e.product) begin
         errors++;
         $display("FAIL %s product: got %h, want %h", name, product, e.product);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_after_done: got %b, want 0", name, busy);
      end
`ifdef ALU_MUL_OVF_EN
      checks++;
      if (ovf !== e.ovf) begin
         errors++;
         $display("FAIL %s ovf: got %b, want %b", name, ovf, e.ovf);
      end
`endif
   endtask

   // Starts at a negedge in IDLE, ends at the negedge of cycle L+1.
   task automatic run_op(input string name, input logic [15:0] ia, input logic [15:0] ib);
      int n;
      sb.push_back(model(ia, ib));
      a     = ia;
      b     = ib;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL %s busy_cycle1: got %b, want 1", name, busy);
      end
      wait_done(name, n);
      check_result(name, n);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got busy=%b done=%b, want 0 0", busy, done);
      end
      checks++;
      if (product !== 16'h0000) begin
         errors++;
         $display("FAIL reset_product: got %h, want 0000", product);
      end
`ifdef ALU_MUL_OVF_EN
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_ovf: got %b, want 0", ovf);
      end
`endif
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      run_op("mul_3x5", 16'd3, 16'd5);
      run_op("mul_b_zero", 16'h1234, 16'h0000);
      run_op("mul_max", 16'hFFFF, 16'hFFFF);
      run_op("mul_mixed", 16'h00AB, 16'h0123);
   endtask

   task automatic test_start_held();
      int n;
      sb.push_back(model(16'd7, 16'd9));
      sb.push_back(model(16'd7, 16'd9));
      a     = 16'd7;
      b     = 16'd9;
      start = 1'b1;
      @(negedge clk);
      wait_done("held_first", n);
      check_result("held_first", n);
      // start still high in cycle L+1: accepted now, so busy by the next cycle
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL held_reaccept: got busy=%b, want 1", busy);
      end
      wait_done("held_second", n);
      check_result("held_second", n);
   endtask

   task automatic test_reset_mid();
      int early_done = 0;
      a     = 16'd100;
      b     = 16'd200;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c < 10; c++) begin
         if (done === 1'b1) early_done++;
         @(negedge clk);
      end
      if (done === 1'b1) early_done++;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (early_done != 0) begin
         errors++;
         $display("FAIL reset_mid_early_done: got %0d pulses, want 0", early_done);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_flags: got busy=%b done=%b, want 0 0", busy, done);
      end
      checks++;
      if (product !== 16'h0000) begin
         errors++;
         $display("FAIL reset_mid_product: got %h, want 0000", product);
      end
      run_op("after_reset_2x3", 16'd2, 16'd3);
   endtask

   task automatic test_back_to_back();
      run_op("b2b_4x4", 16'd4, 16'd4);
      run_op("b2b_100x100", 16'h0100, 16'h0100);
      run_op("b2b_8000x1", 16'h8000, 16'h0001);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_start_held();
      test_reset_mid();
      test_back_to_back();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
